// File: rtl/oven_pkg.sv
// Shared types and constants for the oven cook-cycle controller.
package oven_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StPreheat = 3'd1,
      StReady   = 3'd2,
      StCook    = 3'd3,
      StPause   = 3'd4,
      StDone    = 3'd5,
      StFault   = 3'd6
   } state_e;

   localparam logic [5:0] MAX_SET = 6'd59;
   localparam int unsigned PRESS_PULSE_W = 1;

   function automatic logic [5:0] clamp_set(input logic [5:0] v);
      return (v > MAX_SET) ? MAX_SET : v;
   endfunction

endpackage

// File: rtl/oven_sequencer_if.sv
// Front-panel and heat/timer signal bundle for the oven sequencer.
interface oven_sequencer_if;
   logic       start_n;
   logic       cancel_n;
   logic       temp_reached;
   logic [5:0] set_min;
   logic [5:0] set_sec;
   logic       heater_en;
   logic       cook_active;
   logic       alarm;
   logic       preheat_fault;
   logic [2:0] state;
   logic [5:0] rem_min;
   logic [5:0] rem_sec;

   modport master (
      output start_n, cancel_n, temp_reached, set_min, set_sec,
      input  heater_en, cook_active, alarm, preheat_fault, state, rem_min, rem_sec
   );

   modport slave (
      input  start_n, cancel_n, temp_reached, set_min, set_sec,
      output heater_en, cook_active, alarm, preheat_fault, state, rem_min, rem_sec
   );
endinterface

// File: rtl/button_edge.sv
// Two-flop synchronizer plus falling-edge detect for a raw active-low button.
// A press yields one registered pulse three cycles later, however long it is held.
module button_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n_i,
   output logic press_o
);
   logic s1_q, s2_q, s3_q, pulse_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         s3_q    <= 1'b1;
         pulse_q <= 1'b0;
      end else begin
         s1_q    <= btn_n_i;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         pulse_q <= s3_q & ~s2_q;
      end
   end

   assign press_o = pulse_q;
endmodule

// File: rtl/oven_sequencer.sv
// Cook-cycle controller: button edges, 1 Hz cook tick, state machine, remaining time.
// Optional OVEN_AUTO_START_EN makes READY a one-cycle pass-through into COOK.
module oven_sequencer
   import oven_pkg::*;
#(
   parameter int unsigned CLK_HZ            = 50000000,
   parameter int unsigned ALARM_SECS        = 10,
   parameter int unsigned PREHEAT_TIMEOUT_S = 900
) (
   input logic         clk,
   input logic         rst_n,
   oven_sequencer_if.slave bus
);
   localparam int unsigned DivW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned PreW = $clog2(PREHEAT_TIMEOUT_S + 1);
   localparam int unsigned AlmW = $clog2(ALARM_SECS + 1);

   logic start_p, cancel_p, tick;
   state_e state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
   logic [AlmW-1:0] alm_cnt_q, alm_cnt_d;
   logic [5:0] rem_min_q, rem_min_d, rem_sec_q, rem_sec_d;
   logic heater_q, cook_q, alarm_q, fault_q;

   button_edge u_start (.clk(clk), .rst_n(rst_n), .btn_n_i(bus.start_n), .press_o(start_p));
   button_edge u_cancel (.clk(clk), .rst_n(rst_n), .btn_n_i(bus.cancel_n), .press_o(cancel_p));

   assign tick = (div_q == DivW'(CLK_HZ - 1));

   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      alm_cnt_d = alm_cnt_q;
      rem_min_d = rem_min_q;
      rem_sec_d = rem_sec_q;
      unique case (state_q)
         StIdle: begin
            rem_min_d = clamp_set(bus.set_min);
            rem_sec_d = clamp_set(bus.set_sec);
            pre_cnt_d = '0;
            if (start_p && (|bus.set_min || |bus.set_sec)) state_d = StPreheat;
         end
         StPreheat: begin
            if (cancel_p) state_d = StIdle;
            else if (bus.temp_reached) state_d = StReady;
            else if (tick) begin
               if (pre_cnt_q == PreW'(PREHEAT_TIMEOUT_S - 1)) state_d = StFault;
               else pre_cnt_d = pre_cnt_q + 1'b1;
            end
         end
         StReady: begin
            if (cancel_p) state_d = StIdle;
`ifdef OVEN_AUTO_START_EN
            else state_d = StCook;
`else
            else if (start_p) state_d = StCook;
`endif
         end
         StCook: begin
            alm_cnt_d = '0;
            if (cancel_p) state_d = StIdle;
            else begin
               // Reaching 0:00 takes priority over a pause press on the same cycle.
               if (tick && rem_min_q == 6'd0 && rem_sec_q == 6'd1) begin
                  rem_sec_d = 6'd0;
                  state_d   = StDone;
               end else begin
                  if (tick) begin
                     if (rem_sec_q != 6'd0) rem_sec_d = rem_sec_q - 6'd1;
                     else if (rem_min_q != 6'd0) begin
                        rem_sec_d = MAX_SET;
                        rem_min_d = rem_min_q - 6'd1;
                     end
                  end
                  if (start_p) state_d = StPause;
               end
            end
         end
         StPause: begin
            if (cancel_p) state_d = StIdle;
            else if (start_p) state_d = StCook;
         end
         StDone: begin
            if (start_p || cancel_p) state_d = StIdle;
            else if (tick) begin
               if (alm_cnt_q == AlmW'(ALARM_SECS - 1)) state_d = StIdle;
               else alm_cnt_d = alm_cnt_q + 1'b1;
            end
         end
         StFault: begin
            if (cancel_p) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Divider restarts on every state change so the first tick lands a full second in.
   assign div_d = (state_d != state_q || tick) ? '0 : div_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         div_q     <= '0;
         pre_cnt_q <= '0;
         alm_cnt_q <= '0;
         rem_min_q <= '0;
         rem_sec_q <= '0;
         heater_q  <= 1'b0;
         cook_q    <= 1'b0;
         alarm_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         pre_cnt_q <= pre_cnt_d;
         alm_cnt_q <= alm_cnt_d;
         rem_min_q <= rem_min_d;
         rem_sec_q <= rem_sec_d;
         heater_q  <= (state_d == StPreheat) || (state_d == StReady) ||
                      (state_d == StCook) || (state_d == StPause);
         cook_q    <= (state_d == StCook);
         alarm_q   <= (state_d == StDone);
         fault_q   <= (state_d == StFault);
      end
   end

   assign bus.state         = state_q;
   assign bus.rem_min       = rem_min_q;
   assign bus.rem_sec       = rem_sec_q;
   assign bus.heater_en     = heater_q;
   assign bus.cook_active   = cook_q;
   assign bus.alarm         = alarm_q;
   assign bus.preheat_fault = fault_q;
endmodule
